// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts one block request, strobes key/state load and per-round enables, then holds completion.
// Optional KEY_ZEROIZE_EN: clear the key after every block so each request must supply a fresh key.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          key_new,
  output logic          ld_state,
  output logic          ld_key,
  output logic          round_en,
  output logic [RW-1:0] round_idx,
  output logic          last_round,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          err_nokey,
  output logic          key_clr
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} state_t;

  localparam logic [RW-1:0] LAST_IDX   = RW'(NR);
  localparam logic [RW-1:0] PENULT_IDX = RW'(NR - 1);

  state_t        state, state_d;
  logic          key_loaded, key_loaded_d;
  logic          key_new_q, key_new_q_d;
  logic          ld_state_d, ld_key_d, round_en_d, last_round_d;
  logic          out_valid_d, err_nokey_d, key_clr_d;
  logic [RW-1:0] round_idx_d;

  assign in_ready = (state == IDLE);

  // Outputs are computed one cycle ahead here and registered below.
  always_comb begin
    state_d      = state;
    key_loaded_d = key_loaded;
    key_new_q_d  = key_new_q;
    ld_state_d   = 1'b0;
    ld_key_d     = 1'b0;
    round_en_d   = 1'b0;
    last_round_d = 1'b0;
    out_valid_d  = 1'b0;
    err_nokey_d  = 1'b0;
    key_clr_d    = 1'b0;
    round_idx_d  = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!key_new && !key_loaded) begin
            err_nokey_d = 1'b1;
          end else begin
            state_d     = LOAD;
            key_new_q_d = key_new;
            ld_state_d  = 1'b1;
            ld_key_d    = key_new;
          end
        end
      end
      LOAD: begin
        if (key_new_q) key_loaded_d = 1'b1;
        state_d     = ROUND;
        round_en_d  = 1'b1;
        round_idx_d = RW'(1);
      end
      ROUND: begin
        round_en_d = 1'b1;
        // round_idx doubles as the round counter.
        if (round_idx == PENULT_IDX) begin
          state_d      = FINAL;
          last_round_d = 1'b1;
          round_idx_d  = LAST_IDX;
        end else begin
          round_idx_d = round_idx + 1'b1;
        end
      end
      FINAL: begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        round_idx_d = LAST_IDX;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef KEY_ZEROIZE_EN
          key_clr_d    = 1'b1;
          key_loaded_d = 1'b0;
`endif
        end else begin
          out_valid_d = 1'b1;
          round_idx_d = LAST_IDX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_loaded <= 1'b0;
      key_new_q  <= 1'b0;
      ld_state   <= 1'b0;
      ld_key     <= 1'b0;
      round_en   <= 1'b0;
      last_round <= 1'b0;
      out_valid  <= 1'b0;
      err_nokey  <= 1'b0;
      key_clr    <= 1'b0;
      round_idx  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      key_loaded <= key_loaded_d;
      key_new_q  <= key_new_q_d;
      ld_state   <= ld_state_d;
      ld_key     <= ld_key_d;
      round_en   <= round_en_d;
      last_round <= last_round_d;
      out_valid  <= out_valid_d;
      err_nokey  <= err_nokey_d;
      key_clr    <= key_clr_d;
      round_idx  <= round_idx_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed opening, then random requests/backpressure/resets vs a cycle-count model.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, key_new, out_ready;
  logic          in_ready, ld_state, ld_key, round_en, last_round;
  logic          out_valid, busy, err_nokey, key_clr;
  logic [RW-1:0] round_idx;

  int checks   = 0;
  int failures = 0;

  // Model: a block is "active" for t = 1.. cycles after its accept edge.
  bit m_active     = 0;
  int m_t          = 0;
  bit m_ldk        = 0;
  bit m_key_loaded = 0;
  bit m_err        = 0;
  bit m_kclr       = 0;
  bit m_rst        = 0;

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_new(key_new), .ld_state(ld_state), .ld_key(ld_key),
    .round_en(round_en), .round_idx(round_idx), .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .err_nokey(err_nokey), .key_clr(key_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the reference model across one clock edge with the given inputs.
  task automatic modelEdge(input bit r, input bit iv, input bit kn, input bit ordy);
    m_err  = 0;
    m_kclr = 0;
    m_rst  = r;
    if (r) begin
      m_active     = 0;
      m_key_loaded = 0;
    end else if (!m_active) begin
      if (iv) begin
        if (!kn && !m_key_loaded) m_err = 1;
        else begin
          m_active = 1;
          m_t      = 1;
          m_ldk    = kn;
        end
      end
    end else if (m_t >= NR + 2) begin
      if (ordy) begin
        m_active = 0;
`ifdef KEY_ZEROIZE_EN
        m_kclr       = 1;
        m_key_loaded = 0;
`endif
      end
    end else begin
      if (m_t == 1 && m_ldk) m_key_loaded = 1;
      m_t++;
    end
  endtask

  task automatic checkAll();
    int exp_idx;
    checkOutput("in_ready", in_ready, !m_active);
    checkOutput("busy", busy, m_active);
    checkOutput("ld_state", ld_state, m_active && m_t == 1);
    checkOutput("ld_key", ld_key, m_active && m_t == 1 && m_ldk);
    checkOutput("round_en", round_en, m_active && m_t >= 2 && m_t <= NR + 1);
    checkOutput("last_round", last_round, m_active && m_t == NR + 1);
    checkOutput("out_valid", out_valid, m_active && m_t >= NR + 2);
    checkOutput("err_nokey", err_nokey, m_err);
    checkOutput("key_clr", key_clr, m_kclr);
    if (m_active) begin
      exp_idx = (m_t - 1 > NR) ? NR : m_t - 1;
      checkOutput("round_idx", round_idx, exp_idx);
    end else if (m_rst) begin
      checkOutput("round_idx_rst", round_idx, 0);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit iv, input bit kn, input bit ordy);
    rst       = r;
    in_valid  = iv;
    key_new   = kn;
    out_ready = ordy;
    modelEdge(r, iv, kn, ordy);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    rst = 1; in_valid = 0; key_new = 0; out_ready = 0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1);
    // No key yet: request rejected with a one-cycle error.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    // Full block with new key and immediate consumer.
    applyStimulus(0, 1, 1, 1);
    for (int i = 0; i < NR + 3; i++) applyStimulus(0, 0, 0, 1);
    // Key reuse (or error under zeroize), with backpressure and ignored requests.
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < NR + 6; i++) applyStimulus(0, i[0], 1, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    // Reset mid-block, then a keyless request must be refused.
    applyStimulus(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 50),
                    ($urandom_range(0, 99) < 35),
                    ($urandom_range(0, 99) < 40));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencing controller for the AES-128 encryption datapath. It accepts one block request at a time over a valid/ready handshake and issues the key-load, state-load and per-round enable strobes, with the round index. It then presents completion over a valid/ready output handshake. The block holds no key or data bits itself; it sits between the bus-side wrapper and the AES round/key-expansion datapath.

Parameters:
NR, 10, number of cipher rounds (10 for AES-128); legal range 2..14
RW, 4, width of round_idx; must satisfy 2^RW > NR

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  block request valid
in_ready  output  1  controller can accept a request
key_new  input  1  sampled with request; 1 = datapath loads a new key for this block
ld_state  output  1  one-cycle strobe: datapath loads plaintext and applies round-0 AddRoundKey
ld_key  output  1  one-cycle strobe: datapath loads key register (asserted together with ld_state)
round_en  output  1  datapath executes one round this cycle
round_idx  output  RW  current round number, 0..NR
last_round  output  1  final round (no MixColumns) this cycle
out_valid  output  1  ciphertext valid on datapath output
out_ready  input  1  consumer accepts ciphertext
busy  output  1  FSM not in IDLE
err_nokey  output  1  one-cycle pulse: request rejected, no key loaded
key_clr  output  1  one-cycle strobe: datapath zeroes key register (KEY_ZEROIZE_EN only; else tied 0)

Behaviour:
- Reset: clk and rst as above; reset is synchronous and active-high. On rst=1 at an edge, the FSM goes to IDLE and key_loaded clears. All outputs are 0 the following cycle except in_ready=1. Reset mid-operation abandons the block silently: no out_valid and no err.
- Outputs are registered, except in_ready, which equals (state==IDLE).
- States: IDLE, LOAD, ROUND, FINAL, OUT.
- IDLE: acceptance is in_valid & in_ready at edge T.
  - If key_new=0 and key_loaded=0: the request is dropped, err_nokey=1 in cycle T+1, and the FSM stays in IDLE.
  - Otherwise: go to LOAD, and capture key_new into key_new_q.
- LOAD (one cycle, T+1):
  - ld_state=1, ld_key=key_new_q, round_idx=0, round_en=0.
  - key_loaded is set if key_new_q=1.
  - Go to ROUND.
- ROUND (cycles T+2..T+NR, NR-1 cycles):
  - round_en=1, round_idx runs 1..NR-1 incrementing by 1 per cycle.
  - After round_idx=NR-1, go to FINAL.
- FINAL (one cycle, T+NR+1): round_en=1, last_round=1, round_idx=NR. Go to OUT.
- OUT (from T+NR+2):
  - out_valid=1 and round_idx held at NR.
  - Held until out_ready=1 at an edge, then go to IDLE; out_valid drops the next cycle.
  - out_ready=1 on the first OUT cycle gives exactly one cycle of out_valid.
- Latency: accept edge to first out_valid cycle is NR+2 cycles (12 for NR=10). Minimum back-to-back period is NR+3 cycles.
- No request can be accepted while busy; in_valid is ignored outside IDLE.
- round_idx never exceeds NR and never wraps. round_en and ld_state are never high in the same cycle.
- err_nokey and ld_* are pulses and never stretch.

Optional Feature:
KEY_ZEROIZE_EN
- Defined: on the OUT handshake edge, key_clr=1 for the next cycle (the first IDLE cycle) and key_loaded clears. Every block therefore requires key_new=1; key_new=0 produces err_nokey.
- Undefined: key_clr is constant 0. The key persists across blocks until rst, and key_new=0 reuses it.

Test Plan:
- Reset, then request with key_new=0 at T -> err_nokey=1 at T+1 only; ld_state never asserts; in_ready stays 1.
- Request with key_new=1 at T, out_ready held 1 (NR=10) -> ld_state=ld_key=1 at T+1 with round_idx=0; round_en=1 at T+2..T+11; round_idx 1..10; last_round=1 only at T+11; out_valid=1 only at T+12.
- Second request with key_new=0 right after the first completes (macro undefined) -> ld_state=1 with ld_key=0; same timing; out_valid after 12 cycles.
- out_ready held 0 for 5 cycles in OUT -> out_valid stays 1 and round_idx=10 for 5 cycles; in_valid pulses meanwhile are ignored (no ld_state); IDLE resumes after the handshake.
- rst=1 asserted at T+6 of an active block -> next cycle busy=0, round_en=0, in_ready=1; out_valid is never produced; a following key_new=0 request gives err_nokey=1.
- KEY_ZEROIZE_EN defined: complete a block with key_new=1 -> key_clr=1 for one cycle after the handshake; a following key_new=0 request gives err_nokey=1.
